// File: rtl/hsv_core_alu_q_pkg.sv
// Shared types for the queued core ALU: opcode encoding, FIFO entry layout
// and default sizing constants.
package hsv_core_pkg;

  localparam int ALU_Q_DEFAULT_DEPTH = 4;
  localparam int ALU_Q_DEFAULT_XLEN  = 32;
  localparam int ALU_Q_DEFAULT_TAG_W = 5;

  // Codes 10-15 are legal inputs; they evaluate to zero but still commit.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_t;

  // Output FIFO entry at the default width; the RTL packs {result, tag}
  // in this same order for any XLEN/TAG_W.
  typedef struct packed {
    logic [ALU_Q_DEFAULT_XLEN-1:0]  result;
    logic [ALU_Q_DEFAULT_TAG_W-1:0] tag;
  } alu_q_entry_t;

endpackage

// File: rtl/hsv_core_alu_q_if.sv
// Issue/commit/flush bundle of the queued core ALU.
// The slave side is the ALU itself and the master side is the issue/commit logic.
// alu_op is a raw 4-bit field because codes outside alu_op_t are legal inputs.
interface hsv_core_alu_q_if
  import hsv_core_pkg::*;
#(
  parameter int XLEN  = ALU_Q_DEFAULT_XLEN,
  parameter int TAG_W = ALU_Q_DEFAULT_TAG_W
);
  logic             flush_req;
  logic             flush_ack;
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       alu_op;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_o;
  logic [31:0]      perf_ops;
  logic [31:0]      perf_bp;

  modport slave (
    input  flush_req, valid_i, alu_op, op_a, op_b, tag_i, ready_i,
    output flush_ack, ready_o, valid_o, result, tag_o, perf_ops, perf_bp
  );

  modport master (
    output flush_req, valid_i, alu_op, op_a, op_b, tag_i, ready_i,
    input  flush_ack, ready_o, valid_o, result, tag_o, perf_ops, perf_bp
  );
endinterface

// File: rtl/hsv_core_alu_q_fifo.sv
// Synchronous FIFO holding completed ALU results.
// flush_i empties the FIFO in one edge and discards that edge's push/pop.
// Pops on an empty FIFO are ignored.
module hsv_core_alu_q_fifo
  import hsv_core_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = ALU_Q_DEFAULT_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Next pointer/count; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/hsv_core_alu_q.sv
// Queued core ALU: stage-1 operand register, stage-2 evaluate into an
// OUT_DEPTH-entry result FIFO, credit-based upstream ready.
// Optional macro HSV_ALU_PERF_EN adds pop/backpressure counters; without
// it perf_ops/perf_bp read zero and no counter flops exist.
module hsv_core_alu_q
  import hsv_core_pkg::*;
#(
  parameter int XLEN      = ALU_Q_DEFAULT_XLEN,
  parameter int TAG_W     = ALU_Q_DEFAULT_TAG_W,
  parameter int OUT_DEPTH = ALU_Q_DEFAULT_DEPTH
) (
  input logic             clk_core,
  input logic             rst_core,
  hsv_core_alu_q_if.slave bus
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int CNT_W   = $clog2(OUT_DEPTH) + 1;
  localparam int CRED_W  = CNT_W + 1;
  localparam int ENTRY_W = XLEN + TAG_W;

  logic               s1_valid_q, s1_valid_d;
  logic [3:0]         s1_op_q;
  logic [XLEN-1:0]    s1_a_q, s1_b_q;
  logic [TAG_W-1:0]   s1_tag_q;
  logic               flush_ack_q;

  logic [XLEN-1:0]    s2_result;
  logic [SHAMT_W-1:0] shamt;
  logic               accept, push, pop;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CRED_W-1:0]  credit_need;

  // Credit: every op in the FIFO or in stage 1 owns a FIFO slot, so the
  // pipeline registers never need to stall on commit backpressure.
  assign pop         = !fifo_empty && bus.ready_i;
  assign credit_need = CRED_W'(fifo_count) - CRED_W'(pop) + CRED_W'(s1_valid_q);
  assign bus.ready_o = !bus.flush_req && (credit_need < CRED_W'(OUT_DEPTH));
  assign accept      = bus.valid_i && bus.ready_o;
  assign s1_valid_d  = accept;
  assign push        = s1_valid_q && !bus.flush_req;

  // Stage-1 valid and flush acknowledge; flush drops stage 1 via accept=0.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      s1_valid_q  <= 1'b0;
      flush_ack_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      flush_ack_q <= bus.flush_req;
    end
  end

  // Stage-1 operand capture; data is qualified by s1_valid_q, so no reset.
  always_ff @(posedge clk_core) begin
    if (accept) begin
      s1_op_q  <= bus.alu_op;
      s1_a_q   <= bus.op_a;
      s1_b_q   <= bus.op_b;
      s1_tag_q <= bus.tag_i;
    end
  end

  // Stage-2 evaluation; unknown opcodes yield zero but still commit.
  always_comb begin
    shamt     = s1_b_q[SHAMT_W-1:0];
    s2_result = '0;
    case (s1_op_q)
      OP_ADD:  s2_result = s1_a_q + s1_b_q;
      OP_SUB:  s2_result = s1_a_q - s1_b_q;
      OP_AND:  s2_result = s1_a_q & s1_b_q;
      OP_OR:   s2_result = s1_a_q | s1_b_q;
      OP_XOR:  s2_result = s1_a_q ^ s1_b_q;
      OP_SLL:  s2_result = s1_a_q << shamt;
      OP_SRL:  s2_result = s1_a_q >> shamt;
      OP_SRA:  s2_result = XLEN'($signed(s1_a_q) >>> shamt);
      OP_SLT:  s2_result = XLEN'($signed(s1_a_q) < $signed(s1_b_q));
      OP_SLTU: s2_result = XLEN'(s1_a_q < s1_b_q);
      default: s2_result = '0;
    endcase
  end

  hsv_core_alu_q_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk_i   (clk_core),
    .rst_i   (rst_core),
    .flush_i (bus.flush_req),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({s2_result, s1_tag_q}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.valid_o   = !fifo_empty;
  assign bus.result    = fifo_rdata[ENTRY_W-1:TAG_W];
  assign bus.tag_o     = fifo_rdata[TAG_W-1:0];
  assign bus.flush_ack = flush_ack_q;

`ifdef HSV_ALU_PERF_EN
  logic [31:0] perf_ops_q, perf_bp_q;

  // Wrapping event counters; cleared by reset only, never by flush.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      perf_ops_q <= '0;
      perf_bp_q  <= '0;
    end else begin
      if (pop) perf_ops_q <= perf_ops_q + 32'd1;
      if (bus.valid_i && !bus.ready_o) perf_bp_q <= perf_bp_q + 32'd1;
    end
  end

  assign bus.perf_ops = perf_ops_q;
  assign bus.perf_bp  = perf_bp_q;
`else
  assign bus.perf_ops = '0;
  assign bus.perf_bp  = '0;
`endif

  // Credit accounting must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk_core) disable iff (rst_core)
    !(push && fifo_full));
endmodule

// File: tb/tb_hsv_core_alu_q.sv
// Bench for hsv_core_alu_q: queue-based reference model checked every cycle
// on the falling edge, plus directed scenarios with literal expectations.
module tb_hsv_core_alu_q;
  import hsv_core_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
`ifdef HSV_ALU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk_core = 1'b0;
  logic rst_core = 1'b1;

  hsv_core_alu_q_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  hsv_core_alu_q #(.XLEN(XLEN), .TAG_W(TAG_W), .OUT_DEPTH(DEPTH)) dut (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .bus      (bus)
  );

  always #5 clk_core = ~clk_core;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return 32'($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: vis = results commit can see, pend = op in flight one edge.
  alu_q_entry_t vis[$];
  alu_q_entry_t pend;
  bit           pend_v   = 1'b0;
  bit           ack_m    = 1'b0;
  bit           model_on = 1'b0;
  int unsigned  m_ops    = 0;
  int unsigned  m_bp     = 0;

  always @(negedge clk_core) begin : model
    bit pop_m, rdy_m;
    int need;
    pop_m = (vis.size() > 0) && bus.ready_i;
    need  = vis.size() - (pop_m ? 1 : 0) + (pend_v ? 1 : 0);
    rdy_m = !bus.flush_req && (need < DEPTH);
    if (model_on) begin
      chk("valid_o", bus.valid_o, vis.size() > 0);
      if (vis.size() > 0) begin
        chk("result", bus.result, vis[0].result);
        chk("tag_o", bus.tag_o, vis[0].tag);
      end
      chk("ready_o", bus.ready_o, rdy_m);
      chk("flush_ack", bus.flush_ack, ack_m);
      chk("perf_ops", bus.perf_ops, PERF ? m_ops : 0);
      chk("perf_bp", bus.perf_bp, PERF ? m_bp : 0);
    end
    if (rst_core) begin
      vis.delete();
      pend_v = 1'b0; ack_m = 1'b0; m_ops = 0; m_bp = 0; model_on = 1'b1;
    end else if (model_on) begin
      ack_m = bus.flush_req;
      if (bus.valid_i && !rdy_m) m_bp++;
      if (pop_m) begin
        void'(vis.pop_front());
        m_ops++;
      end
      if (bus.flush_req) begin
        vis.delete();
        pend_v = 1'b0;
      end else begin
        if (pend_v) vis.push_back(pend);
        pend_v = bus.valid_i && rdy_m;
        if (pend_v) begin
          pend.result = ref_alu(bus.alu_op, bus.op_a, bus.op_b);
          pend.tag    = bus.tag_i;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic set_op(input bit v, input int op, input logic [31:0] a,
                        input logic [31:0] b, input int t);
    bus.valid_i = v;
    bus.alu_op  = 4'(op);
    bus.op_a    = a;
    bus.op_b    = b;
    bus.tag_i   = 5'(t);
  endtask

  task automatic do_reset(input int n);
    rst_core = 1'b1;
    repeat (n) tick();
    rst_core = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int nxt;
    int popped[$];
    bit acc;
    bus.flush_req = 1'b0;
    bus.ready_i   = 1'b1;
    set_op(0, 0, 0, 0, 0);

    // Reset state.
    do_reset(3);
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_ready_o", bus.ready_o, 1);
    chk("rst_flush_ack", bus.flush_ack, 0);
    chk("rst_perf_ops", bus.perf_ops, 0);
    chk("rst_perf_bp", bus.perf_bp, 0);

    // ADD wrap, exact 2-cycle latency.
    set_op(1, 0, 32'hFFFF_FFFF, 32'h1, 3);
    tick();
    set_op(0, 0, 0, 0, 0);
    chk("add_not_early", bus.valid_o, 0);
    tick();
    chk("add_valid", bus.valid_o, 1);
    chk("add_result", bus.result, 32'h0);
    chk("add_tag", bus.tag_o, 3);
    tick();

    // SRA / SLTU / SLT back to back.
    set_op(1, 7, 32'h8000_0000, 32'd4, 1);
    tick();
    set_op(1, 9, 32'h1, 32'hFFFF_FFFF, 2);
    tick();
    chk("sra_result", bus.result, 32'hF800_0000);
    set_op(1, 8, 32'h1, 32'hFFFF_FFFF, 3);
    tick();
    chk("sltu_result", bus.result, 32'h1);
    set_op(0, 0, 0, 0, 0);
    tick();
    chk("slt_result", bus.result, 32'h0);
    chk("slt_tag", bus.tag_o, 3);
    tick();

    // Commit stall: only DEPTH ops are accepted, then all 6 drain in order.
    bus.ready_i = 1'b0;
    nxt = 0;
    for (int c = 0; c < 12; c++) begin
      set_op(nxt < 6, 0, 32'(nxt * 10), 32'd1, 10 + nxt);
      #1;
      acc = bus.valid_i && bus.ready_o;
      tick();
      if (acc) nxt++;
    end
    chk("bp_accepted", nxt, 4);
    bus.ready_i = 1'b1;
    for (int c = 0; c < 30 && popped.size() < 6; c++) begin
      set_op(nxt < 6, 0, 32'(nxt * 10), 32'd1, 10 + nxt);
      #1;
      acc = bus.valid_i && bus.ready_o;
      if (bus.valid_o && bus.ready_i) popped.push_back(int'(bus.tag_o));
      tick();
      if (acc) nxt++;
    end
    set_op(0, 0, 0, 0, 0);
    chk("bp_pop_count", popped.size(), 6);
    foreach (popped[i]) chk("bp_pop_order", popped[i], 10 + i);
    tick();

    // 100 ops back to back with ready_i=1: full throughput.
    for (int i = 0; i < 100; i++) begin
      set_op(1, $urandom_range(0, 9), $urandom, $urandom, i % 32);
      #1;
      chk("b2b_ready", bus.ready_o, 1);
      if (i >= 2) begin
        chk("b2b_valid", bus.valid_o, 1);
        chk("b2b_tag", bus.tag_o, (i - 2) % 32);
      end
      tick();
    end
    set_op(0, 0, 0, 0, 0);
    repeat (3) tick();

    // Flush with 3 ops in the FIFO and 1 in stage 1.
    bus.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_op(1, 1, 32'd100, 32'(i), 20 + i);
      tick();
    end
    set_op(0, 0, 0, 0, 0);
    bus.flush_req = 1'b1;
    #1;
    chk("flush_ready_low", bus.ready_o, 0);
    tick();
    bus.flush_req = 1'b0;
    chk("flush_ack", bus.flush_ack, 1);
    chk("flush_valid_o", bus.valid_o, 0);
    bus.ready_i = 1'b1;
    set_op(1, 0, 32'd2, 32'd3, 7);
    tick();
    set_op(0, 0, 0, 0, 0);
    chk("flush_ack_one_cycle", bus.flush_ack, 0);
    chk("post_flush_not_early", bus.valid_o, 0);
    tick();
    chk("post_flush_valid", bus.valid_o, 1);
    chk("post_flush_result", bus.result, 32'd5);
    chk("post_flush_tag", bus.tag_o, 7);
    tick();

    // Performance counters: 10 pops, 5 stalled-input cycles.
    do_reset(2);
    bus.ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_op(1, 3, 32'(i), 32'h100, i);
      tick();
    end
    set_op(0, 0, 0, 0, 0);
    bus.ready_i = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 6; i++) begin
      set_op(1, 2, $urandom, $urandom, i);
      tick();
    end
    set_op(0, 0, 0, 0, 0);
    repeat (4) tick();
    chk("perf_ops_10", bus.perf_ops, PERF ? 10 : 0);
    chk("perf_bp_5", bus.perf_bp, PERF ? 5 : 0);

    // Randomized traffic with occasional flush and mid-stream reset.
    for (int c = 0; c < 3000; c++) begin
      set_op($urandom_range(0, 9) < 7, $urandom_range(0, 15),
             ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
             ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
             $urandom_range(0, 31));
      bus.ready_i   = $urandom_range(0, 9) < 6;
      bus.flush_req = $urandom_range(0, 99) < 3;
      rst_core      = $urandom_range(0, 199) == 0;
      tick();
    end
    rst_core      = 1'b0;
    bus.flush_req = 1'b0;
    bus.ready_i   = 1'b1;
    set_op(0, 0, 0, 0, 0);
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
